controlador_base_tempo: RTL and testbench

Sequencing controller for the lab timing datapath. It generates a single-cycle tick enable at one of four selectable periods (0.5 s, 1 s, 2 s, 6 s at 50 MHz) and drives a wrap-around decimal counter with it. A start/pause/clear state machine controls the counter. Period changes are deferred to tick boundaries so a period is never truncated. Downstream display logic uses tick and contagem, not derived clocks.

---
 rtl/tempo_pkg.sv | 42 ++++
 rtl/divisor_tick.sv | 43 ++++
 rtl/tempo_param_chk.sv | 27 ++
 rtl/controlador_base_tempo.sv | 131 +++++++++++++
 tb/tb_controlador_base_tempo.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tempo_pkg.sv
// Shared types and defaults for the lab time-base controller.
package tempo_pkg;

  // Controller states, encoded as seen on the estado output.
  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2
  } estado_t;

  // Period selection codes.
  localparam logic [1:0] SEL_05S = 2'd0;
  localparam logic [1:0] SEL_1S  = 2'd1;
  localparam logic [1:0] SEL_2S  = 2'd2;
  localparam logic [1:0] SEL_6S  = 2'd3;

  // Default divisors for a 50 MHz clock.
  localparam int DIV_05S_DEF   = 25_000_000;
  localparam int DIV_1S_DEF    = 50_000_000;
  localparam int DIV_2S_DEF    = 100_000_000;
  localparam int DIV_6S_DEF    = 300_000_000;
  localparam int CW_DEF        = 29;
  localparam int MAX_COUNT_DEF = 9;

  // Next value of the wrap-around decimal counter.
  function automatic logic [3:0] passo_contagem(
    input logic [3:0] atual,
    input logic       descendo,
    input logic [3:0] maximo
  );
    logic [3:0] prox;
    if (descendo) begin
      if (atual == 4'd0) prox = maximo;
      else               prox = atual - 4'd1;
    end else begin
      if (atual >= maximo) prox = 4'd0;
      else                 prox = atual + 4'd1;
    end
    return prox;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler with enable, synchronous clear and runtime terminal value.
// o_fim flags the edge on which the period completes; o_tick is the
// registered one-cycle pulse that follows that edge.
module divisor_tick #(
  parameter int CW = 29
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [CW-1:0] i_limit,
  output logic          o_fim,
  output logic          o_tick
);

  logic [CW-1:0] r_presc;
  logic          r_tick;

  assign o_fim  = i_en && !i_clr && (r_presc == i_limit);
  assign o_tick = r_tick;

  // Prescaler advance, wrap at the limit and registered tick pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_en) begin
      if (r_presc == i_limit) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + CW'(1);
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tempo_param_chk.sv
// Parameter sanity checks for the time-base controller.
module tempo_param_chk #(
  parameter int DIV_0     = 4,
  parameter int DIV_1     = 8,
  parameter int DIV_2     = 16,
  parameter int DIV_3     = 48,
  parameter int CW        = 29,
  parameter int MAX_COUNT = 9
) (
  input logic clk_in,
  input logic rst_n
);

  // Divisors must be at least 2, fit the prescaler, and the count must fit 4 bits.
  always @(posedge clk_in) begin
    if (rst_n) begin
      assert (DIV_0 >= 2 && DIV_1 >= 2 && DIV_2 >= 2 && DIV_3 >= 2)
        else $error("tempo_param_chk: divisor below 2");
      assert (((DIV_0 - 1) >> CW) == 0 && ((DIV_1 - 1) >> CW) == 0 &&
              ((DIV_2 - 1) >> CW) == 0 && ((DIV_3 - 1) >> CW) == 0)
        else $error("tempo_param_chk: divisor does not fit prescaler width");
      assert (MAX_COUNT >= 1 && MAX_COUNT <= 15)
        else $error("tempo_param_chk: MAX_COUNT out of range");
    end
  end

endmodule

// File: rtl/controlador_base_tempo.sv
// Time-base controller: start/pause/clear FSM, deferred period selection
// and a wrap-around decimal counter stepped by the period tick.
module controlador_base_tempo
  import tempo_pkg::*;
#(
  parameter int DIV_0     = DIV_05S_DEF,
  parameter int DIV_1     = DIV_1S_DEF,
  parameter int DIV_2     = DIV_2S_DEF,
  parameter int DIV_3     = DIV_6S_DEF,
  parameter int CW        = CW_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       descendo,
  output logic       tick,
  output logic [3:0] contagem,
  output logic [1:0] sel_ativo,
  output logic [1:0] estado
);

  localparam logic [CW-1:0] LIM_0  = CW'(DIV_0 - 1);
  localparam logic [CW-1:0] LIM_1  = CW'(DIV_1 - 1);
  localparam logic [CW-1:0] LIM_2  = CW'(DIV_2 - 1);
  localparam logic [CW-1:0] LIM_3  = CW'(DIV_3 - 1);
  localparam logic [3:0]    MAX_C  = 4'(MAX_COUNT);

  estado_t       r_estado;
  logic [1:0]    r_sel_ativo;
  logic [3:0]    r_contagem;
  logic [CW-1:0] w_limit;
  logic          w_en;
  logic          w_clr;
  logic          w_fim;
  logic          w_tick;

  assign tick      = w_tick;
  assign contagem  = r_contagem;
  assign sel_ativo = r_sel_ativo;
  assign estado    = r_estado;

  // Stopping or clearing freezes the prescaler on the very edge they are seen.
  assign w_en  = (r_estado == CONTANDO) && !clear && !stop;
  assign w_clr = clear || (r_estado == PARADO);

  // Terminal prescaler value for the period currently in force.
  always_comb begin
    w_limit = LIM_0;
    case (r_sel_ativo)
      SEL_05S: w_limit = LIM_0;
      SEL_1S:  w_limit = LIM_1;
      SEL_2S:  w_limit = LIM_2;
      SEL_6S:  w_limit = LIM_3;
      default: w_limit = LIM_0;
    endcase
  end

  divisor_tick #(
    .CW (CW)
  ) u_divisor_tick (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_limit (w_limit),
    .o_fim   (w_fim),
    .o_tick  (w_tick)
  );

  tempo_param_chk #(
    .DIV_0     (DIV_0),
    .DIV_1     (DIV_1),
    .DIV_2     (DIV_2),
    .DIV_3     (DIV_3),
    .CW        (CW),
    .MAX_COUNT (MAX_COUNT)
  ) u_param_chk (
    .clk_in (clk_in),
    .rst_n  (rst_n)
  );

  // Control FSM with the sel_ativo latch and the decimal counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= PARADO;
      r_sel_ativo <= SEL_05S;
      r_contagem  <= 4'd0;
    end else if (clear) begin
      r_estado   <= PARADO;
      r_contagem <= 4'd0;
      if (r_estado == PARADO) r_sel_ativo <= sel;
      else                    r_sel_ativo <= r_sel_ativo;
    end else begin
      case (r_estado)
        PARADO: begin
          r_sel_ativo <= sel;
          if (stop)       r_estado <= PARADO;
          else if (start) r_estado <= CONTANDO;
          else            r_estado <= PARADO;
        end
        CONTANDO: begin
          if (stop) begin
            r_estado <= PAUSADO;
          end else begin
            r_estado <= CONTANDO;
            if (w_fim) begin
              r_contagem  <= passo_contagem(r_contagem, descendo, MAX_C);
              r_sel_ativo <= sel;
            end else begin
              r_contagem  <= r_contagem;
            end
          end
        end
        PAUSADO: begin
          if (stop)       r_estado <= PAUSADO;
          else if (start) r_estado <= CONTANDO;
          else            r_estado <= PAUSADO;
        end
        default: begin
          r_estado   <= PARADO;
          r_contagem <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_base_tempo.sv
// Directed and randomized bench for controlador_base_tempo with a
// period/elapsed-time reference model.
module tb_controlador_base_tempo;

  localparam int D0 = 4, D1 = 8, D2 = 16, D3 = 48, MAXC = 9;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       start, stop, clear, descendo;
  logic       tick;
  logic [3:0] contagem;
  logic [1:0] sel_ativo;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state;   // 0 stopped, 1 running, 2 paused
  int m_elapsed; // cycles elapsed in the current period
  int m_sel;
  int m_count;
  int m_tick;

  controlador_base_tempo #(
    .DIV_0(D0), .DIV_1(D1), .DIV_2(D2), .DIV_3(D3), .CW(29), .MAX_COUNT(MAXC)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sel(sel), .start(start), .stop(stop),
    .clear(clear), .descendo(descendo), .tick(tick), .contagem(contagem),
    .sel_ativo(sel_ativo), .estado(estado)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int period_of(input int s);
    case (s)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_sel = 0; m_count = 0; m_tick = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      if (m_state == 0) m_sel = int'(sel);
      m_state = 0; m_elapsed = 0; m_count = 0; m_tick = 0;
    end else if (m_state == 0) begin
      m_sel = int'(sel);
      m_tick = 0;
      if (!stop && start) m_state = 1;
    end else if (m_state == 1) begin
      if (stop) begin
        m_state = 2;
        m_tick = 0;
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == period_of(m_sel)) begin
          m_elapsed = 0;
          m_tick = 1;
          if (descendo) m_count = (m_count + MAXC) % (MAXC + 1);
          else          m_count = (m_count + 1) % (MAXC + 1);
          m_sel = int'(sel);
        end else begin
          m_tick = 0;
        end
      end
    end else begin
      m_tick = 0;
      if (!stop && start) m_state = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    chk("tick", 32'(tick), 32'(m_tick));
    chk("contagem", 32'(contagem), 32'(m_count));
    chk("sel_ativo", 32'(sel_ativo), 32'(m_sel));
    chk("estado", 32'(estado), 32'(m_state));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until the DUT shows a tick; n is the cycle count, capped at the bound.
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < bound);
    if (tick !== 1'b1) n = bound + 1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  initial begin
    int n;
    int held;
    int nticks;
    rst_n = 1'b0; sel = 2'd0; start = 1'b0; stop = 1'b0; clear = 1'b0; descendo = 1'b0;
    model_reset();
    cycles(3);
    chk("reset_estado", 32'(estado), 32'd0);
    chk("reset_contagem", 32'(contagem), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // 1: sel=0, count up through a full wrap
    sel = 2'd0; descendo = 1'b0;
    pulse_start();
    wait_tick(200, n);
    chk("t1_first_latency", 32'(n), 32'd4);
    for (int i = 0; i < 9; i++) begin
      wait_tick(200, n);
      chk("t1_interval", 32'(n), 32'd4);
    end
    chk("t1_wrap_contagem", 32'(contagem), 32'd0);

    // 2: period change mid-period takes effect only at the tick
    pulse_clear();
    sel = 2'd1;
    pulse_start();
    wait_tick(200, n);
    chk("t2_first_sel1", 32'(n), 32'd8);
    cycles(3);
    sel = 2'd0;
    chk("t2_sel_ativo_before", 32'(sel_ativo), 32'd1);
    wait_tick(200, n);
    chk("t2_old_period_completes", 32'(n + 3), 32'd8);
    chk("t2_sel_ativo_at_tick", 32'(sel_ativo), 32'd0);
    wait_tick(200, n);
    chk("t2_new_period", 32'(n), 32'd4);

    // 3: pause at prescaler 10 of 16, resume continues the period
    pulse_clear();
    sel = 2'd2;
    pulse_start();
    wait_tick(200, n);
    chk("t3_first_sel2", 32'(n), 32'd16);
    cycles(10);
    held = int'(contagem);
    stop = 1'b1;
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick === 1'b1) nticks++;
    end
    stop = 1'b0;
    chk("t3_no_tick_paused", 32'(nticks), 32'd0);
    chk("t3_contagem_held", 32'(contagem), 32'(held));
    chk("t3_estado_paused", 32'(estado), 32'd2);
    pulse_start();
    wait_tick(200, n);
    chk("t3_resume_latency", 32'(n), 32'd6);

    // 4: count down wraps 0 -> 9, then clear silences everything
    pulse_clear();
    sel = 2'd0; descendo = 1'b1;
    pulse_start();
    wait_tick(200, n);
    chk("t4_down_wrap", 32'(contagem), 32'd9);
    pulse_clear();
    chk("t4_clear_estado", 32'(estado), 32'd0);
    chk("t4_clear_contagem", 32'(contagem), 32'd0);
    nticks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (tick === 1'b1) nticks++;
    end
    chk("t4_no_tick_after_clear", 32'(nticks), 32'd0);
    descendo = 1'b0;

    // 5: stop beats start; clear beats start
    pulse_start();
    cycles(2);
    start = 1'b1; stop = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
    chk("t5_stop_wins", 32'(estado), 32'd2);
    start = 1'b1; clear = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    chk("t5_clear_wins", 32'(estado), 32'd0);

    // 6: asynchronous reset mid-period on sel=3
    sel = 2'd3;
    pulse_start();
    wait_tick(200, n);
    chk("t6_first_sel3", 32'(n), 32'd48);
    cycles(20);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_tick", 32'(tick), 32'd0);
    chk("t6_async_contagem", 32'(contagem), 32'd0);
    chk("t6_async_sel_ativo", 32'(sel_ativo), 32'd0);
    chk("t6_async_estado", 32'(estado), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      clear    = ($urandom_range(99) < 2);
      stop     = ($urandom_range(99) < 5);
      start    = ($urandom_range(99) < 20);
      descendo = $urandom_range(1);
      if ($urandom_range(99) < 10) sel = 2'($urandom_range(3));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
